// File: rtl/qspi_tx_wr_arbiter_pkg.sv
// qspi_tx_wr_arbiter_pkg: state and grant encodings shared by the TX write arbiter
package qspi_tx_wr_arbiter_pkg;
  typedef enum logic {IDLE, BURST} state_t;
  typedef enum logic {GNT_CPU, GNT_DMA} gnt_t;
endpackage

// File: rtl/qspi_tx_wr_arbiter_rr_arb2.sv
// qspi_tx_wr_arbiter_rr_arb2: two-requester round-robin arbiter with last-grant update
module qspi_tx_wr_arbiter_rr_arb2
  import qspi_tx_wr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic cpu_req,
  input  logic dma_req,
  input  logic upd,
  input  gnt_t upd_gnt,
  output gnt_t gnt
);
  gnt_t last;
  always_ff @(posedge clk)
    if (!resetn) last <= GNT_DMA;
    else if (upd) last <= upd_gnt;
  assign gnt = (cpu_req && dma_req) ? ((last == GNT_CPU) ? GNT_DMA : GNT_CPU)
             : (dma_req ? GNT_DMA : GNT_CPU);
endmodule

// File: rtl/qspi_tx_wr_arbiter.sv
// qspi_tx_wr_arbiter: shares the TX FIFO write port between CPU and DMA with locked DMA bursts
module qspi_tx_wr_arbiter
  import qspi_tx_wr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 4,
  parameter int BURST_LEN = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable_i,
  input  logic [7:0]       watermark_i,
  input  logic             cpu_valid_i,
  input  logic [WIDTH-1:0] cpu_data_i,
  output logic             cpu_ready_o,
  input  logic             dma_valid_i,
  input  logic [WIDTH-1:0] dma_data_i,
  output logic             dma_ready_o,
  output logic             dma_req_o,
  output logic             burst_abort_o,
  output logic             fifo_wr_en_o,
  output logic [WIDTH-1:0] fifo_wr_data_o,
  input  logic             fifo_full_i,
  input  logic [7:0]       fifo_level_i
);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam int IW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [BW-1:0] beat_cnt, beat_n;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [8:0] lvl;
  logic en, space, ok, cpu_xfer, dma_xfer, upd;
  gnt_t gnt, upd_gnt;
  assign lvl = {1'b0, fifo_level_i};
  assign en = enable_i && resetn;
  // the registered write still in flight already occupies a slot
  assign space = !fifo_full_i && ((lvl + {8'd0, fifo_wr_en_o}) < 9'(DEPTH));
  assign ok = en && space;
  assign cpu_xfer = cpu_valid_i && cpu_ready_o;
  assign dma_xfer = dma_valid_i && dma_ready_o;
  qspi_tx_wr_arbiter_rr_arb2 u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .cpu_req (cpu_valid_i),
    .dma_req (dma_valid_i),
    .upd     (upd),
    .upd_gnt (upd_gnt),
    .gnt     (gnt)
  );
  always_comb begin
    state_n = state;
    beat_n = beat_cnt;
    idle_n = idle_cnt;
    upd = 1'b0;
    upd_gnt = GNT_DMA;
    cpu_ready_o = 1'b0;
    dma_ready_o = 1'b0;
    burst_abort_o = 1'b0;
    if (!en) begin
      state_n = IDLE;
      beat_n = '0;
      idle_n = '0;
    end else if (state == IDLE) begin
      cpu_ready_o = cpu_valid_i && (gnt == GNT_CPU) && ok;
      dma_ready_o = dma_valid_i && (gnt == GNT_DMA) && ok;
      if (cpu_ready_o) begin
        upd = 1'b1;
        upd_gnt = GNT_CPU;
      end else if (dma_ready_o) begin
        if (BURST_LEN == 1) upd = 1'b1;
        else begin
          state_n = BURST;
          beat_n = BW'(1);
          idle_n = '0;
        end
      end
    end else begin
      dma_ready_o = ok;
      if (dma_valid_i && ok) begin
        idle_n = '0;
        if (beat_cnt == BW'(BURST_LEN - 1)) begin
          state_n = IDLE;
          beat_n = '0;
          upd = 1'b1;
        end else beat_n = beat_cnt + 1'b1;
      end else if (!dma_valid_i && space) begin
        if (idle_cnt == IW'(TIMEOUT - 1)) begin
          state_n = IDLE;
          beat_n = '0;
          idle_n = '0;
          burst_abort_o = 1'b1;
          upd = 1'b1;
        end else idle_n = idle_cnt + 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      beat_cnt <= '0;
      idle_cnt <= '0;
      fifo_wr_en_o <= 1'b0;
      fifo_wr_data_o <= '0;
      dma_req_o <= 1'b0;
    end else begin
      state <= state_n;
      beat_cnt <= beat_n;
      idle_cnt <= idle_n;
      fifo_wr_en_o <= cpu_xfer || dma_xfer;
      if (cpu_xfer || dma_xfer) fifo_wr_data_o <= cpu_xfer ? cpu_data_i : dma_data_i;
      dma_req_o <= enable_i && (state == IDLE) && (lvl <= {1'b0, watermark_i})
                   && ((lvl + 9'(BURST_LEN)) <= 9'(DEPTH));
    end
  end
endmodule

// File: tb/tb_qspi_tx_wr_arbiter.sv
// tb_qspi_tx_wr_arbiter: table-driven directed check of the TX write arbiter
module tb_qspi_tx_wr_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic enable_i = 1'b1;
  logic [7:0] watermark_i = 8'd1;
  logic cpu_valid_i = 1'b0;
  logic [31:0] cpu_data_i = '0;
  logic cpu_ready_o;
  logic dma_valid_i = 1'b0;
  logic [31:0] dma_data_i = '0;
  logic dma_ready_o, dma_req_o, burst_abort_o, fifo_wr_en_o;
  logic [31:0] fifo_wr_data_o;
  logic fifo_full_i = 1'b0;
  logic [7:0] fifo_level_i = '0;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  qspi_tx_wr_arbiter #(.WIDTH(32), .DEPTH(4), .BURST_LEN(2), .TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .enable_i(enable_i), .watermark_i(watermark_i),
    .cpu_valid_i(cpu_valid_i), .cpu_data_i(cpu_data_i), .cpu_ready_o(cpu_ready_o),
    .dma_valid_i(dma_valid_i), .dma_data_i(dma_data_i), .dma_ready_o(dma_ready_o),
    .dma_req_o(dma_req_o), .burst_abort_o(burst_abort_o), .fifo_wr_en_o(fifo_wr_en_o),
    .fifo_wr_data_o(fifo_wr_data_o), .fifo_full_i(fifo_full_i), .fifo_level_i(fifo_level_i)
  );
  typedef struct {
    logic rstn, en, cv;
    logic [31:0] cd;
    logic dv;
    logic [31:0] dd;
    logic full;
    logic [7:0] lvl;
    logic chk, cr, dr, ab, we;
    logic [31:0] wd;
    logic req;
  } vec_t;
  function automatic vec_t v(logic rstn, logic en, logic cv, logic [31:0] cd, logic dv,
                             logic [31:0] dd, logic full, logic [7:0] lvl, logic chk,
                             logic cr, logic dr, logic ab, logic we, logic [31:0] wd, logic req);
    vec_t r;
    r = '{rstn, en, cv, cd, dv, dd, full, lvl, chk, cr, dr, ab, we, wd, req};
    return r;
  endfunction
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic apply(vec_t x, string tag);
    @(negedge clk);
    resetn = x.rstn;
    enable_i = x.en;
    cpu_valid_i = x.cv;
    cpu_data_i = x.cd;
    dma_valid_i = x.dv;
    dma_data_i = x.dd;
    fifo_full_i = x.full;
    fifo_level_i = x.lvl;
    #1;
    if (x.chk) begin
      check({tag, " cpu_ready"}, {31'd0, cpu_ready_o}, {31'd0, x.cr});
      check({tag, " dma_ready"}, {31'd0, dma_ready_o}, {31'd0, x.dr});
      check({tag, " burst_abort"}, {31'd0, burst_abort_o}, {31'd0, x.ab});
    end
    @(posedge clk);
    #1;
    check({tag, " wr_en"}, {31'd0, fifo_wr_en_o}, {31'd0, x.we});
    check({tag, " wr_data"}, fifo_wr_data_o, x.wd);
    check({tag, " dma_req"}, {31'd0, dma_req_o}, {31'd0, x.req});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    vec_t tbl[$];
    // CPU stream A0..A3, then the in-flight write and a full FIFO block it
    tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,0, 0,0,0));
    tbl.push_back(v(1,1,1,'hA0,0,0,0,0, 1,1,0,0, 1,'hA0,1));
    tbl.push_back(v(1,1,1,'hA1,0,0,0,0, 1,1,0,0, 1,'hA1,1));
    tbl.push_back(v(1,1,1,'hA2,0,0,0,1, 1,1,0,0, 1,'hA2,1));
    tbl.push_back(v(1,1,1,'hA3,0,0,0,2, 1,1,0,0, 1,'hA3,0));
    tbl.push_back(v(1,1,1,'hA4,0,0,0,3, 1,0,0,0, 0,'hA3,0));
    tbl.push_back(v(1,1,1,'hA4,0,0,1,4, 1,0,0,0, 0,'hA3,0));
    tbl.push_back(v(1,1,0,0,0,0,0,0, 1,0,0,0, 0,'hA3,1));
    // tie from reset: CPU, DMA, DMA (burst), CPU
    tbl.push_back(v(0,1,0,0,0,0,0,0, 0,0,0,0, 0,0,0));
    tbl.push_back(v(1,1,1,'hC0,1,'hD0,0,0, 1,1,0,0, 1,'hC0,1));
    tbl.push_back(v(1,1,1,'hC1,1,'hD0,0,0, 1,0,1,0, 1,'hD0,1));
    tbl.push_back(v(1,1,1,'hC1,1,'hD1,0,1, 1,0,1,0, 1,'hD1,0));
    tbl.push_back(v(1,1,1,'hC1,1,'hD2,0,2, 1,1,0,0, 1,'hC1,0));
    tbl.push_back(v(1,1,0,0,0,0,0,0, 1,0,0,0, 0,'hC1,1));
    // level 3: second burst word waits for the in-flight write to land
    tbl.push_back(v(1,1,0,0,1,'hD3,0,3, 1,0,1,0, 1,'hD3,0));
    tbl.push_back(v(1,1,0,0,1,'hD4,0,3, 1,0,0,0, 0,'hD3,0));
    tbl.push_back(v(1,1,0,0,1,'hD4,1,4, 1,0,0,0, 0,'hD3,0));
    tbl.push_back(v(1,1,0,0,1,'hD4,1,4, 1,0,0,0, 0,'hD3,0));
    tbl.push_back(v(1,1,0,0,1,'hD4,0,3, 1,0,1,0, 1,'hD4,0));
    tbl.push_back(v(1,1,0,0,0,0,1,4, 1,0,0,0, 0,'hD4,0));
    // watermark request 0 -> 2 -> 0, then enable low
    tbl.push_back(v(1,1,0,0,0,0,0,0, 1,0,0,0, 0,'hD4,1));
    tbl.push_back(v(1,1,0,0,0,0,0,2, 1,0,0,0, 0,'hD4,0));
    tbl.push_back(v(1,1,0,0,0,0,0,0, 1,0,0,0, 0,'hD4,1));
    tbl.push_back(v(1,0,1,'hA5,0,0,0,0, 1,0,0,0, 0,'hD4,0));
    tbl.push_back(v(1,0,0,0,1,'hD5,0,0, 1,0,0,0, 0,'hD4,0));
    tbl.push_back(v(1,1,0,0,0,0,0,0, 1,0,0,0, 0,'hD4,1));
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
    // one burst word then silence: abort on the 16th idle cycle
    apply(v(1,1,0,0,1,'hE0,0,0, 1,0,1,0, 1,'hE0,1), "abort_start");
    for (int k = 1; k <= 16; k++)
      apply(v(1,1,0,0,0,0,0,0, 1,0,1,(k == 16), 0,'hE0,0), $sformatf("abort_idle%0d", k));
    apply(v(1,1,1,'hF0,0,0,0,0, 1,1,0,0, 1,'hF0,1), "abort_cpu");
    // reset in the middle of a burst, then a tie goes to the CPU
    apply(v(1,1,0,0,1,'hB0,0,0, 1,0,1,0, 1,'hB0,1), "rst_burst");
    apply(v(0,1,0,0,0,0,0,0, 1,0,0,0, 0,0,0), "rst_mid");
    apply(v(1,1,1,'hB1,1,'hB2,0,0, 1,1,0,0, 1,'hB1,1), "rst_tie");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
